// File: rtl/clk_ratio_meter_if.sv
// -----------------------------------------------------------------------------
// clk_ratio_meter_if
// Bundles the measurement control inputs and the result outputs of
// clk_ratio_meter. The clock and reset stay plain ports on the meter.
//
//   i_en          enable; low returns the meter to IDLE
//   i_div_clk     slow clock / strobe being measured (same i_clk domain)
//   o_ratio       last measured period in i_clk cycles
//   o_ratio_valid one-cycle pulse when o_ratio is updated
//   o_locked      the same period has been seen LOCK_COUNT times in a row
//   o_overflow    sticky: a period ran past the counter range
//   o_high_time   high cycles within the last measured period (0 when the
//                 duty-cycle option is not built)
//
// Modports:
//   master - drives i_en / i_div_clk and observes the results
//   slave  - the meter itself
// RATIO_WIDTH must match the RATIO_WIDTH of the connected meter.
// -----------------------------------------------------------------------------
interface clk_ratio_meter_if #(
    parameter int RATIO_WIDTH = 8
);
    logic                   i_en;
    logic                   i_div_clk;
    logic [RATIO_WIDTH-1:0] o_ratio;
    logic                   o_ratio_valid;
    logic                   o_locked;
    logic                   o_overflow;
    logic [RATIO_WIDTH-1:0] o_high_time;

    modport master (
        output i_en,
        output i_div_clk,
        input  o_ratio,
        input  o_ratio_valid,
        input  o_locked,
        input  o_overflow,
        input  o_high_time
    );

    modport slave (
        input  i_en,
        input  i_div_clk,
        output o_ratio,
        output o_ratio_valid,
        output o_locked,
        output o_overflow,
        output o_high_time
    );
endinterface

// File: rtl/clk_ratio_meter.sv
// -----------------------------------------------------------------------------
// clk_ratio_meter
// Measures the period of a slow, same-domain divided clock or strobe in units
// of i_clk and reports it as an integer ratio. A divider programmed with
// ratio R produces a signal this block reports as R. Lock is declared after
// LOCK_COUNT consecutive identical periods; a period longer than the counter
// range raises a sticky overflow flag.
//
// Parameters:
//   RATIO_WIDTH  width of the period counter and of o_ratio (max period
//                2^RATIO_WIDTH-1, min period 2)
//   LOCK_COUNT   consecutive identical periods needed for lock, 2..15
//
// Ports:
//   i_clk   system clock, rising edge
//   i_rst   synchronous active-high reset, highest priority
//   bus     clk_ratio_meter_if.slave (i_en, i_div_clk in; results out)
//
// Optional feature:
//   CLK_RATIO_METER_DUTY_EN  when defined, a high-time counter is built and
//   o_high_time reports the number of high cycles in the last period. When
//   not defined, o_high_time is tied to 0.
//
// i_div_clk is sampled directly; it must already be synchronous to i_clk.
// All outputs are registered.
// -----------------------------------------------------------------------------
module clk_ratio_meter #(
    parameter int RATIO_WIDTH = 8,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    clk_ratio_meter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam logic [RATIO_WIDTH-1:0] CNT_ZERO  = {RATIO_WIDTH{1'b0}};
    localparam logic [RATIO_WIDTH-1:0] CNT_ONE   = {{(RATIO_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RATIO_WIDTH-1:0] CNT_MAX   = {RATIO_WIDTH{1'b1}};
    localparam logic [3:0]             MCNT_LOCK = 4'(LOCK_COUNT);

    state_t                 state_q,  state_d;
    logic                   prev_q;
    logic [RATIO_WIDTH-1:0] cnt_q,    cnt_d;
    logic [RATIO_WIDTH-1:0] ratio_q,  ratio_d;
    logic [3:0]             mcnt_q,   mcnt_d;
    logic                   valid_q,  valid_d;
    logic                   locked_q, locked_d;
    logic                   ovf_q,    ovf_d;

    logic                   rise_s;
    logic                   in_meas_s;
    logic                   wrap_s;
    logic [3:0]             mcnt_hit_s;

    assign rise_s    = bus.i_div_clk & ~prev_q;
    assign in_meas_s = (state_q == ST_MEASURE) || (state_q == ST_LOCKED);
    // A rise on the all-ones count is still a valid period; only a missing
    // rise there means the period does not fit the counter.
    assign wrap_s    = (cnt_q == CNT_MAX) & ~rise_s;

    // Match-counter value to use when a period completes: a repeat of the
    // previous period extends the run (saturating at the lock threshold),
    // anything else, or the first period after a restart, starts a new run.
    always_comb begin
        mcnt_hit_s = 4'd1;
        if ((cnt_q == ratio_q) && (mcnt_q != 4'd0)) begin
            if (mcnt_q >= MCNT_LOCK) begin
                mcnt_hit_s = MCNT_LOCK;
            end else begin
                mcnt_hit_s = mcnt_q + 4'd1;
            end
        end else begin
            mcnt_hit_s = 4'd1;
        end
    end

    // Next-state and next-output computation for the measurement FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ratio_d  = ratio_q;
        mcnt_d   = mcnt_q;
        valid_d  = 1'b0;
        locked_d = locked_q;
        ovf_d    = ovf_q;

        if (!bus.i_en) begin
            // Disable discards any partial period and clears status; the
            // last reported ratio is kept.
            state_d  = ST_IDLE;
            cnt_d    = CNT_ZERO;
            mcnt_d   = 4'd0;
            locked_d = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEARCH;
                end
                ST_SEARCH: begin
                    // The first rise only marks the start of a period.
                    if (rise_s) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_MEASURE;
                    end else begin
                        cnt_d   = cnt_q;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (rise_s) begin
                        ratio_d = cnt_q;
                        valid_d = 1'b1;
                        cnt_d   = CNT_ONE;
                        mcnt_d  = mcnt_hit_s;
                        if (mcnt_hit_s == MCNT_LOCK) begin
                            locked_d = 1'b1;
                            state_d  = ST_LOCKED;
                        end else begin
                            // Covers both "not yet locked" and "locked but
                            // the period changed" (run restarted at 1).
                            locked_d = 1'b0;
                            state_d  = ST_MEASURE;
                        end
                    end else if (wrap_s) begin
                        ovf_d    = 1'b1;
                        locked_d = 1'b0;
                        mcnt_d   = 4'd0;
                        cnt_d    = CNT_ZERO;
                        state_d  = ST_SEARCH;
                    end else begin
                        cnt_d    = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    cnt_d    = CNT_ZERO;
                    mcnt_d   = 4'd0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            prev_q   <= 1'b0;
            cnt_q    <= CNT_ZERO;
            ratio_q  <= CNT_ZERO;
            mcnt_q   <= 4'd0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= bus.i_div_clk;
            cnt_q    <= cnt_d;
            ratio_q  <= ratio_d;
            mcnt_q   <= mcnt_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.o_ratio       = ratio_q;
    assign bus.o_ratio_valid = valid_q;
    assign bus.o_locked      = locked_q;
    assign bus.o_overflow    = ovf_q;

`ifdef CLK_RATIO_METER_DUTY_EN
    logic [RATIO_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [RATIO_WIDTH-1:0] high_q, high_d;

    // High-time counter: counts high cycles alongside cnt (the rise cycle
    // itself counts as one) and is captured together with o_ratio.
    always_comb begin
        hcnt_d = hcnt_q;
        high_d = high_q;
        if (!bus.i_en || (state_q == ST_IDLE) || (in_meas_s && wrap_s)) begin
            hcnt_d = CNT_ZERO;
        end else if (rise_s && ((state_q == ST_SEARCH) || in_meas_s)) begin
            if (in_meas_s) begin
                high_d = hcnt_q;
            end else begin
                high_d = high_q;
            end
            hcnt_d = CNT_ONE;
        end else if (in_meas_s) begin
            hcnt_d = hcnt_q + {{(RATIO_WIDTH-1){1'b0}}, bus.i_div_clk};
        end else begin
            hcnt_d = hcnt_q;
        end
    end

    // High-time registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hcnt_q <= CNT_ZERO;
            high_q <= CNT_ZERO;
        end else begin
            hcnt_q <= hcnt_d;
            high_q <= high_d;
        end
    end

    assign bus.o_high_time = high_q;
`else
    assign bus.o_high_time = {RATIO_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_clk_ratio_meter.sv
// -----------------------------------------------------------------------------
// tb_clk_ratio_meter
// Directed bench for clk_ratio_meter (RATIO_WIDTH=8, LOCK_COUNT=4). Each
// period whose closing rise must produce a valid pulse gets its expected
// ratio / lock / high-time pushed to a queue just before the rise is driven;
// a negedge monitor pops and compares on every o_ratio_valid pulse.
// -----------------------------------------------------------------------------
module tb_clk_ratio_meter;

    typedef struct packed {
        logic [7:0] ratio;
        logic       locked;
        logic [7:0] high;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    clk_ratio_meter_if #(.RATIO_WIDTH(8)) bus ();

    clk_ratio_meter #(
        .RATIO_WIDTH(8),
        .LOCK_COUNT (4)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int exp_high(input int h);
`ifdef CLK_RATIO_METER_DUTY_EN
        return h;
`else
        return 0 * h;
`endif
    endfunction

    // One i_clk cycle with the given i_div_clk level; returns at the negedge.
    task automatic tick(input logic v);
        bus.i_div_clk = v;
        @(negedge clk);
    endtask

    task automatic run(input int h, input int l);
        repeat (h) tick(1'b1);
        repeat (l) tick(1'b0);
    endtask

    task automatic push(input int r, input bit lk, input int h);
        exp_t e;
        e.ratio  = 8'(r);
        e.locked = lk;
        e.high   = 8'(exp_high(h));
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: every valid pulse must have a pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.o_ratio_valid === 1'b1) begin
            check("valid_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("ratio",     32'(bus.o_ratio),     32'(e.ratio));
                check("locked",    32'(bus.o_locked),    32'(e.locked));
                check("high_time", 32'(bus.o_high_time), 32'(e.high));
            end
        end
    end

    initial begin
        // Reset with enable high and the input toggling.
        rst = 1'b1;
        bus.i_en = 1'b1;
        bus.i_div_clk = 1'b0;
        tick(1'b1);
        tick(1'b0);
        check("rst_ratio",  32'(bus.o_ratio),       32'd0);
        check("rst_valid",  32'(bus.o_ratio_valid), 32'd0);
        check("rst_locked", 32'(bus.o_locked),      32'd0);
        check("rst_ovf",    32'(bus.o_overflow),    32'd0);
        check("rst_high",   32'(bus.o_high_time),   32'd0);
        rst = 1'b0;
        tick(1'b0);
        tick(1'b0);

        // Period 4 (2 high / 2 low): first rise only starts measuring.
        run(2, 2);
        for (int i = 0; i < 6; i++) begin
            push(4, (i >= 3), 2);
            run(2, 2);
        end

        // Switch to period 6 (3/3) while locked.
        push(4, 1'b1, 2);
        run(3, 3);
        push(6, 1'b0, 3); run(3, 3);
        push(6, 1'b0, 3); run(3, 3);
        push(6, 1'b0, 3); run(3, 3);
        push(6, 1'b1, 3); run(3, 3);
        push(6, 1'b1, 3); run(3, 3);

        // Drop enable for one cycle mid-period while locked.
        push(6, 1'b1, 3);
        tick(1'b1); tick(1'b1); tick(1'b1); tick(1'b0);
        bus.i_en = 1'b0;
        tick(1'b0);
        check("en_drop_locked", 32'(bus.o_locked),      32'd0);
        check("en_drop_ovf",    32'(bus.o_overflow),    32'd0);
        check("en_drop_valid",  32'(bus.o_ratio_valid), 32'd0);
        bus.i_en = 1'b1;
        tick(1'b0);
        run(3, 3);
        push(6, 1'b0, 3); run(3, 3);

        // Overflow: rise, then hold low for 300 cycles.
        push(6, 1'b0, 3);
        tick(1'b1);
        repeat (254) tick(1'b0);
        check("ovf_before", 32'(bus.o_overflow), 32'd0);
        tick(1'b0);
        check("ovf_set",    32'(bus.o_overflow), 32'd1);
        check("ovf_ratio",  32'(bus.o_ratio),    32'd6);
        check("ovf_locked", 32'(bus.o_locked),   32'd0);
        repeat (45) tick(1'b0);
        run(2, 2);
        push(4, 1'b0, 2); run(2, 2);
        check("ovf_sticky", 32'(bus.o_overflow), 32'd1);

        // Disable clears the sticky flag.
        bus.i_en = 1'b0;
        tick(1'b0);
        check("ovf_clear", 32'(bus.o_overflow), 32'd0);
        bus.i_en = 1'b1;
        tick(1'b0);

        // Largest period (255): valid measurement, no overflow.
        run(1, 254);
        push(255, 1'b0, 1); run(1, 1);
        check("max_no_ovf", 32'(bus.o_overflow), 32'd0);

        // Alternating 1/0: period 2, locking on the 4th pulse.
        push(2, 1'b0, 1); run(1, 1);
        push(2, 1'b0, 1); run(1, 1);
        push(2, 1'b0, 1); run(1, 1);
        push(2, 1'b1, 1); run(2, 3);

        // Period 5 (2 high / 3 low).
        push(5, 1'b0, 2); run(2, 3);
        push(5, 1'b0, 2);
        tick(1'b1); tick(1'b1); tick(1'b0);

        // Reset mid-period.
        rst = 1'b1;
        tick(1'b0);
        check("mid_rst_ratio",  32'(bus.o_ratio),       32'd0);
        check("mid_rst_valid",  32'(bus.o_ratio_valid), 32'd0);
        check("mid_rst_locked", 32'(bus.o_locked),      32'd0);
        check("mid_rst_high",   32'(bus.o_high_time),   32'd0);
        rst = 1'b0;
        tick(1'b0);
        tick(1'b0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_ratio_meter.md
# clk_ratio_meter

Measures the period of a slow, same-domain divided clock or strobe in units of the system clock and reports it as an integer ratio, with lock and overflow indication. It is the receiving end of the clock-divider path: a divider programmed with ratio R produces a signal that this block reports as R. It is used for built-in self-checking of divider outputs and for recovering the divide ratio of an incoming slow tick.

## Interface
- RATIO_WIDTH, 8: width of the period counter and of o_ratio; largest measurable period is 2^RATIO_WIDTH-1.
- LOCK_COUNT, 4: number of consecutive identical periods required to assert o_locked; legal range 2..15.

- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  reset, synchronous, active-high; highest priority.
- i_en  in  1  measurement enable; low forces IDLE.
- i_div_clk  in  1  signal under measurement; synchronous to i_clk, not resynchronised.
- o_ratio  out  RATIO_WIDTH  last measured period in i_clk cycles; reset 0.
- o_ratio_valid  out  1  one-cycle pulse when o_ratio is updated; reset 0.
- o_locked  out  1  LOCK_COUNT consecutive identical periods seen; reset 0.
- o_overflow  out  1  sticky: period exceeded counter range; reset 0.
- o_high_time  out  RATIO_WIDTH  high cycles within the last measured period; reset 0; see Configuration.

## Operation
- prev register holds the previous sample of i_div_clk; rise = i_div_clk & ~prev. prev updates every cycle, in every state. Reset clears it to 0.
- Period counter cnt (RATIO_WIDTH bits); match counter mcnt (4 bits).
- States: IDLE, SEARCH, MEASURE, LOCKED.
- IDLE: o_locked=0, o_overflow=0, o_ratio_valid=0, o_ratio holds. Go to SEARCH when i_en=1.
- i_en=0 in any state: go to IDLE next cycle. No valid pulse is produced, and any partial period is discarded.
- SEARCH: on rise, set cnt<=1 and go to MEASURE. The partial period is never reported.
- MEASURE/LOCKED, no rise: cnt<=cnt+1.
- MEASURE/LOCKED, rise:
  - o_ratio<=cnt, o_ratio_valid<=1, cnt<=1.
  - If cnt equals the current o_ratio and mcnt>0: mcnt<=mcnt+1. Otherwise mcnt<=1.
  - If the new mcnt equals LOCK_COUNT: o_locked<=1 and go to LOCKED. mcnt saturates at LOCK_COUNT.
  - If in LOCKED and cnt differs from o_ratio: o_locked<=0, go to MEASURE, mcnt<=1.
- Overflow: in MEASURE/LOCKED, if cnt is all-ones and there is no rise:
  - o_overflow<=1, o_locked<=0, mcnt<=0, go to SEARCH.
  - o_ratio holds its value. o_overflow stays set until i_en=0 or i_rst.
- A rise with cnt all-ones is a valid measurement, not an overflow.
- Minimum measurable period is 2. mcnt=0 after reset, IDLE or overflow, so the first measured period never counts as a match.

## Timing
- o_ratio, o_ratio_valid and o_locked update on the same edge that samples the rise. They are visible in the following cycle.
- Latency from the first rise to the first o_ratio_valid is one full period. o_locked asserts with the LOCK_COUNT-th valid pulse of an unchanged period.
- o_overflow is visible the cycle after the edge at which cnt=all-ones is sampled with no rise.
- i_rst mid-period: everything returns to reset values next cycle, state IDLE.

## Configuration
- CLK_RATIO_METER_DUTY_EN defined:
  - A high-time counter loads 1 on each rise and adds i_div_clk on every other cycle of the period.
  - Its value is captured into o_high_time together with o_ratio, and is cleared on overflow and in IDLE.
- Not defined: o_high_time is tied to 0 and no high-time logic is built. All other behaviour is identical.

## Test plan
- Reset: drive i_rst=1 for 2 cycles with i_en=1 and i_div_clk toggling -> all outputs 0, state IDLE.
- Period 4 (2 high/2 low), LOCK_COUNT=4, i_en=1 -> o_ratio=4 with a valid pulse every 4 cycles; o_locked rises with the 4th valid pulse.
- While locked at 4, switch to period 6 -> o_locked falls with the first valid pulse carrying 6; it re-asserts with the 4th consecutive valid pulse of 6.
- RATIO_WIDTH=8: hold i_div_clk low for 300 cycles after a rise -> o_overflow=1 at 255 cycles, o_ratio unchanged. The next rise gives no valid pulse; the rise after it gives a valid pulse.
- Alternating 1/0 input -> o_ratio=2 every 2 cycles. With the macro and period 5 (2 high/3 low) -> o_ratio=5, o_high_time=2.
- Drop i_en for 1 cycle mid-period while locked -> o_locked=0 and o_overflow=0 next cycle, no spurious valid; first new valid pulse comes one full period after the next rise.
